// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: PCSel and FSM state encodings.
package instr_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned JT_W    = 26;

  typedef enum logic [1:0] {
    PC_NEXT_INS = 2'b00,
    PC_REL_JMP  = 2'b01,
    PC_ABS_JMP  = 2'b10,
    PC_HALT     = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    IF_IDLE   = 2'b00,
    IF_FETCH  = 2'b01,
    IF_VALID  = 2'b10,
    IF_HALTED = 2'b11
  } if_state_e;

  // Forces the two low address bits to zero so the PC stays word-aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory handshake plus the control-unit interface.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  // control unit -> fetch
  pc_sel_e           PCSel;
  logic [XLEN-1:0]   Immediate;
  logic [JT_W-1:0]   JumpTarget;
  logic              InsAccept;
  // instruction memory
  logic [XLEN-1:0]   IAddr;
  logic              IReq;
  logic [XLEN-1:0]   IRdata;
  logic              IReady;
  // fetch -> control unit
  logic [XLEN-1:0]   PC;
  logic [XLEN-1:0]   PC4;
  logic [XLEN-1:0]   Instruction;
  logic [OPC_W-1:0]  Opcode;
  logic [FUNCT_W-1:0] Funct;
  logic              InsValid;
  logic              Halted;
  logic              FetchErr;

  modport master (
    input  PCSel, Immediate, JumpTarget, InsAccept, IRdata, IReady,
    output IAddr, IReq, PC, PC4, Instruction, Opcode, Funct, InsValid, Halted, FetchErr
  );

  modport slave (
    output PCSel, Immediate, JumpTarget, InsAccept, IRdata, IReady,
    input  IAddr, IReq, PC, PC4, Instruction, Opcode, Funct, InsValid, Halted, FetchErr
  );

endinterface

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC selection; the halt case is resolved by the caller, which holds the PC.
module instr_fetch_next_pc
  import instr_fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc4_i,
  input  pc_sel_e         pc_sel_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [JT_W-1:0] jump_target_i,
  output logic [XLEN-1:0] next_pc_o
);

  always_comb begin
    next_pc_o = pc4_i;
    case (pc_sel_i)
      PC_NEXT_INS: next_pc_o = pc4_i;
      PC_REL_JMP:  next_pc_o = pc4_i + (imm_i << 2);
      PC_ABS_JMP:  next_pc_o = {pc4_i[XLEN-1:XLEN-4], jump_target_i, 2'b00};
      default:     next_pc_o = pc4_i;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, fetch FSM and instruction register.
// Optional fetch timeout is compiled in with IF_TIMEOUT_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic          CLK,
  input  logic          nReset,
  instr_fetch_if.master bus
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            ireq_q, ireq_d;
  logic            ins_valid_q, ins_valid_d;
  logic            halted_q, halted_d;
  logic            fetch_err_q, fetch_err_d;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] target;

`ifdef IF_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             expired;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  assign pc4 = pc_q + XLEN'(4);

  instr_fetch_next_pc u_next_pc (
    .pc4_i         (pc4),
    .pc_sel_i      (bus.PCSel),
    .imm_i         (bus.Immediate),
    .jump_target_i (bus.JumpTarget),
    .next_pc_o     (target)
  );

`ifdef IF_TIMEOUT_EN
  // Counter is zero whenever we are outside FETCH, so it is clear on every entry.
  assign expired = (wait_cnt_q == CNT_LAST);

  always_comb begin
    wait_cnt_d = '0;
    if (state_q == IF_FETCH && !bus.IReady && !expired) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end
`endif

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      IF_IDLE: state_d = IF_FETCH;
      IF_FETCH: begin
        if (bus.IReady) begin
          instr_d = bus.IRdata;
          state_d = IF_VALID;
        end
`ifdef IF_TIMEOUT_EN
        else if (expired) begin
          fetch_err_d = 1'b1;
          state_d     = IF_HALTED;
        end
`endif
      end
      IF_VALID: begin
        if (bus.InsAccept) begin
          if (bus.PCSel == PC_HALT) begin
            state_d = IF_HALTED;
          end else begin
            pc_d    = align_word(target);
            state_d = IF_FETCH;
          end
        end
      end
      IF_HALTED: state_d = IF_HALTED;
      default:   state_d = IF_IDLE;
    endcase
    ireq_d      = (state_d == IF_FETCH);
    ins_valid_d = (state_d == IF_VALID);
    halted_d    = (state_d == IF_HALTED);
  end

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IF_IDLE;
      pc_q        <= align_word(RESET_PC);
      instr_q     <= '0;
      ireq_q      <= 1'b0;
      ins_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
`ifdef IF_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      ireq_q      <= ireq_d;
      ins_valid_q <= ins_valid_d;
      halted_q    <= halted_d;
      fetch_err_q <= fetch_err_d;
`ifdef IF_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign bus.IAddr       = pc_q;
  assign bus.IReq        = ireq_q;
  assign bus.PC          = pc_q;
  assign bus.PC4         = pc4;
  assign bus.Instruction = instr_q;
  assign bus.Opcode      = instr_q[31:26];
  assign bus.Funct       = instr_q[5:0];
  assign bus.InsValid    = ins_valid_q;
  assign bus.Halted      = halted_q;
  assign bus.FetchErr    = fetch_err_q;

endmodule
